vga_pixel_renderer: RTL and testbench

VGA_PIXEL_RENDERER -- requirements
Module: vga_pixel_renderer

---
 rtl/vga_pixel_renderer.sv | 152 +++++++++++++++
 tb/tb_vga_pixel_renderer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_renderer.sv
// vga_pixel_renderer
// Two-stage pixel pipeline for a grid game on a 640x480 VGA raster.
// Stage 1 maps the pixel position to a board-RAM cell address and flags
// border cells; stage 2 turns the returned cell code into a colour. The sync
// inputs are delayed to stay aligned with colour, and a frame counter derives
// the game-step strobe from the vertical-sync indication.
module vga_pixel_renderer #(
    parameter int FRAMES_PER_STEP = 10,
    parameter int CELL_SHIFT      = 4,
    parameter int GRID_W          = 40,
    parameter int GRID_H          = 30
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        display_area,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        frame_tik,
    output logic [10:0] rd_addr,
    input  logic [1:0]  rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        h_sync,
    output logic        v_sync,
    output logic        game_tick
);

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BODY  = 2'b01,
        CELL_HEAD  = 2'b10,
        CELL_FOOD  = 2'b11
    } cell_e;

    localparam logic [9:0]  X_ORIGIN  = 10'd48;
    localparam logic [9:0]  Y_ORIGIN  = 10'd34;
    localparam logic [10:0] ROW_PITCH = 11'(GRID_W);
    localparam logic [9:0]  CX_LAST   = 10'(GRID_W - 1);
    localparam logic [9:0]  CY_LAST   = 10'(GRID_H - 1);
    localparam logic [5:0]  CNT_LAST  = 6'(FRAMES_PER_STEP - 1);

    // Position relative to the active-region origin, then in cell units.
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic [9:0]  w_cx;
    logic [9:0]  w_cy;
    logic [10:0] w_addr;
    logic        w_wall;
    logic        w_ft_rise;

    assign w_px   = X - X_ORIGIN;
    assign w_py   = Y - Y_ORIGIN;
    assign w_cx   = w_px >> CELL_SHIFT;
    assign w_cy   = w_py >> CELL_SHIFT;
    assign w_addr = {1'b0, w_cy} * ROW_PITCH + {1'b0, w_cx};
    assign w_wall = (w_cx == 10'd0) || (w_cx == CX_LAST) ||
                    (w_cy == 10'd0) || (w_cy == CY_LAST);

    logic [10:0] r_rd_addr;
    logic        r_de1;
    logic        r_wall1;
    logic [11:0] r_rgb;
    logic [1:0]  r_hs_dly;
    logic [1:0]  r_vs_dly;
    logic        r_ft;
    logic [5:0]  r_frame_cnt;
    logic        r_game_tick;

    // Stage 1: cell address lookup, display-enable and border flag.
    // NOTE: every register below uses <= so all stages sample the values from
    // before the edge; blocking assignments here would collapse the pipeline.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_rd_addr <= 11'd0;
            r_de1     <= 1'b0;
            r_wall1   <= 1'b0;
        end else begin
            // NOTE: the hold during blanking is an enable on a flop, not an
            // incomplete combinational assignment, so no latch results.
            if (display_area) begin
                r_rd_addr <= w_addr;
            end
            r_de1   <= display_area;
            r_wall1 <= w_wall;
        end
    end

    // Stage 2: decode the cell code returned by the board RAM into a colour.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_rgb <= 12'h000;
        end else if (!r_de1) begin
            r_rgb <= 12'h000;
        end else if (r_wall1) begin
            r_rgb <= 12'h888;
        end else begin
            case (cell_e'(rd_data))
                CELL_EMPTY: r_rgb <= 12'h000;
                CELL_BODY:  r_rgb <= 12'h0F0;
                CELL_HEAD:  r_rgb <= 12'hFF0;
                CELL_FOOD:  r_rgb <= 12'hF00;
                default:    r_rgb <= 12'h000;
            endcase
        end
    end

    // Two-cycle sync delay matching the colour latency; idles inactive-high.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_hs_dly <= 2'b11;
            r_vs_dly <= 2'b11;
        end else begin
            r_hs_dly <= {r_hs_dly[0], h_sync_in};
            r_vs_dly <= {r_vs_dly[0], v_sync_in};
        end
    end

    // A frame_tik already high at reset release is not a new frame.
    assign w_ft_rise = frame_tik && !r_ft;

    // Frame counter: one game_tick strobe every FRAMES_PER_STEP frames.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_ft        <= 1'b1;
            r_frame_cnt <= 6'd0;
            r_game_tick <= 1'b0;
        end else begin
            r_ft        <= frame_tik;
            r_game_tick <= 1'b0;
            if (w_ft_rise) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= 6'd0;
                    r_game_tick <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign h_sync    = r_hs_dly[1];
    assign v_sync    = r_vs_dly[1];
    assign game_tick = r_game_tick;

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// tb_vga_pixel_renderer
// Randomised and directed stimulus against a reference model that works from
// pixel coordinates, cycle-indexed input history and frame-edge counting.
module tb_vga_pixel_renderer;

    localparam int FPS  = 10;
    localparam int NMAX = 8192;

    logic        clock_25     = 1'b0;
    logic        reset        = 1'b0;
    logic [9:0]  X            = '0;
    logic [9:0]  Y            = '0;
    logic        display_area = 1'b0;
    logic        h_sync_in    = 1'b1;
    logic        v_sync_in    = 1'b1;
    logic        frame_tik    = 1'b1;
    logic [1:0]  rd_data      = '0;
    logic [10:0] rd_addr;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        h_sync;
    logic        v_sync;
    logic        game_tick;

    always #20 clock_25 = ~clock_25;

    vga_pixel_renderer dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .X            (X),
        .Y            (Y),
        .display_area (display_area),
        .h_sync_in    (h_sync_in),
        .v_sync_in    (v_sync_in),
        .frame_tik    (frame_tik),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .game_tick    (game_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Input history, one entry per clock step, and model state.
    int hx  [NMAX];
    int hy  [NMAX];
    bit hde [NMAX];
    bit hhs [NMAX];
    bit hvs [NMAX];
    int hrd [NMAX];
    int n        = 0;
    int base     = 0;
    int exp_addr = 0;
    int edges    = 0;
    bit prev_ft  = 1'b1;
    int ticks_seen = 0;
    bit cur_hs = 1'b1;
    bit cur_vs = 1'b1;
    bit cur_ft = 1'b1;

    function automatic int cell_col(input int x); return (x - 48) / 16; endfunction
    function automatic int cell_row(input int y); return (y - 34) / 16; endfunction

    function automatic bit is_wall(input int x, input int y);
        return cell_col(x) == 0 || cell_col(x) == 39 || cell_row(y) == 0 || cell_row(y) == 29;
    endfunction

    function automatic int colour_of(input int code);
        case (code)
            1:       return 'h0F0;
            2:       return 'hFF0;
            3:       return 'hF00;
            default: return 'h000;
        endcase
    endfunction

    // Drive one step, clock it, then compare every output with the model.
    task automatic cycle(input int x, input int y, input bit de, input bit hs,
                         input bit vs, input int rd, input bit ft);
        int k;
        int exp_rgb;
        bit rising;
        bit exp_tick;
        if (n >= NMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", n, NMAX);
            $fatal(1);
        end
        X = 10'(x); Y = 10'(y); display_area = de;
        h_sync_in = hs; v_sync_in = vs; rd_data = 2'(rd); frame_tik = ft;
        hx[n] = x; hy[n] = y; hde[n] = de; hhs[n] = hs; hvs[n] = vs; hrd[n] = rd;
        if (de) exp_addr = cell_row(y) * 40 + cell_col(x);
        rising  = ft && !prev_ft;
        prev_ft = ft;
        if (rising) edges++;
        exp_tick = rising && (edges % FPS == 0);
        @(posedge clock_25);
        #1;
        n++;
        k = n - 2;
        if (k < base || !hde[k])      exp_rgb = 'h000;
        else if (is_wall(hx[k], hy[k])) exp_rgb = 'h888;
        else                           exp_rgb = colour_of(hrd[n-1]);
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        check("sync", 32'({h_sync, v_sync}),
              (k < base) ? 32'd3 : 32'({hhs[k], hvs[k]}));
        check("game_tick", 32'(game_tick), 32'(exp_tick));
        if (game_tick) ticks_seen++;
    endtask

    // Random pixel in or out of the active region, boundary values favoured.
    task automatic rand_cycle();
        int x, y, rd;
        bit de;
        de = ($urandom_range(9, 0) != 0);
        if (de) begin
            case ($urandom_range(9, 0))
                0:       begin x = 48;  y = $urandom_range(512, 34); end
                1:       begin x = 687; y = $urandom_range(512, 34); end
                2:       begin x = $urandom_range(687, 48); y = 34;  end
                3:       begin x = $urandom_range(687, 48); y = 512; end
                default: begin x = $urandom_range(687, 48); y = $urandom_range(512, 34); end
            endcase
        end else begin
            x = $urandom_range(799, 0);
            y = $urandom_range(524, 0);
        end
        rd = $urandom_range(3, 0);
        cycle(x, y, de, cur_hs, cur_vs, rd, cur_ft);
    endtask

    // Asynchronous reset entered between clock edges, outputs checked at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_sync", 32'({h_sync, v_sync}), 32'd3);
        check("rst_tick", 32'(game_tick), 32'd0);
        repeat (3) @(posedge clock_25);
        #1;
        check("rst_hold_addr", 32'(rd_addr), 32'd0);
        reset    = 1'b1;
        base     = n;
        exp_addr = 0;
        edges    = 0;
        prev_ft  = 1'b1;
    endtask

    // A frame: frame_tik high for hi cycles, then low for lo cycles.
    task automatic frames(input int count, input int hi, input int lo);
        for (int f = 0; f < count; f++) begin
            cur_ft = 1'b1;
            for (int i = 0; i < hi; i++) rand_cycle();
            cur_ft = 1'b0;
            for (int i = 0; i < lo; i++) rand_cycle();
        end
    endtask

    int t0;
    int lut [4] = '{'h000, 'h0F0, 'hFF0, 'hF00};

    initial begin
        @(posedge clock_25);
        #1;
        do_reset();

        // frame_tik already high when reset releases: must not count.
        cur_ft = 1'b1;
        for (int i = 0; i < 5; i++) rand_cycle();

        // Address mapping corners.
        cycle(48, 34, 1, 1, 1, 0, 1);
        check("addr_origin", 32'(rd_addr), 32'd0);
        cycle(687, 512, 1, 1, 1, 0, 1);
        check("addr_last", 32'(rd_addr), 32'd1199);
        cycle(64, 50, 1, 1, 1, 0, 1);
        check("addr_41", 32'(rd_addr), 32'd41);
        cycle(100, 100, 0, 1, 1, 0, 1);
        check("addr_hold", 32'(rd_addr), 32'd41);

        // Colour pipeline for every code at an interior cell.
        for (int c = 0; c < 4; c++) begin
            cycle(64, 50, 1, 1, 1, 0, 1);
            cycle(64, 50, 1, 1, 1, c, 1);
            check("colour_code", 32'({vga_r, vga_g, vga_b}), 32'(lut[c]));
        end

        // Wall override and blanking.
        cycle(48, 200, 1, 1, 1, 0, 1);
        cycle(48, 200, 1, 1, 1, 3, 1);
        check("wall_override", 32'({vga_r, vga_g, vga_b}), 32'h888);
        cycle(300, 200, 0, 1, 1, 0, 1);
        cycle(300, 200, 0, 1, 1, 1, 1);
        check("blank_black", 32'({vga_r, vga_g, vga_b}), 32'h000);

        // 96-cycle sync pulses, each output tracked cycle by cycle.
        cur_hs = 1'b0;
        for (int i = 0; i < 96; i++) rand_cycle();
        cur_hs = 1'b1;
        for (int i = 0; i < 4; i++) rand_cycle();
        cur_vs = 1'b0;
        for (int i = 0; i < 96; i++) rand_cycle();
        cur_vs = 1'b1;
        for (int i = 0; i < 4; i++) rand_cycle();

        // Thirty frames from a clean reset give exactly three strobes.
        do_reset();
        cur_ft = 1'b0;
        rand_cycle();
        t0 = ticks_seen;
        frames(30, 7, 9);
        check("ticks_30_frames", 32'(ticks_seen - t0), 32'd3);

        // Reset with seven frames counted; the count restarts from zero.
        do_reset();
        cur_ft = 1'b0;
        rand_cycle();
        frames(7, 3, 3);
        cur_ft = 1'b1;
        rand_cycle();
        do_reset();
        cur_ft = 1'b0;
        rand_cycle();
        t0 = ticks_seen;
        frames(9, 3, 3);
        check("no_tick_after_9", 32'(ticks_seen - t0), 32'd0);
        frames(1, 3, 3);
        check("tick_after_10", 32'(ticks_seen - t0), 32'd1);

        // Long random run with random sync and frame_tik activity.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(11, 0) == 0) cur_ft = ~cur_ft;
            if ($urandom_range(49, 0) == 0) cur_hs = ~cur_hs;
            if ($urandom_range(79, 0) == 0) cur_vs = ~cur_vs;
            rand_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
